fb_write_arbiter: RTL and testbench

- Shares the single framebuffer pixel-write port (mem_px_addr / mem_px_data / px_wr) between two pixel-painting clients.
- Client 0 is the button/cursor painter; client 1 is a pattern or sprite writer.
- Contains a built-in clear sequencer that sweeps the whole buffer to a fixed colour on request.
- Sits between the game-logic FSMs and the dual-port pixel memory that the VGA scanout reads.

---
 rtl/fb_write_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_write_arbiter
//  Description : Shares the framebuffer pixel-write port between two painting
//                clients (round-robin on ties). Includes a clear sequencer
//                that sweeps every valid pixel to a fixed colour on request.
//  Revision    : 1.0  initial release
// ============================================================================
module fb_write_arbiter #(
  parameter int              AW        = 8,
  parameter int              DW        = 3,
  parameter int              NPIX      = 192,
  parameter logic [DW-1:0]   CLR_COLOR = 3'b111
) (
  input  logic          gameclk,
  input  logic          rst,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] data0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] data1,
  output logic          gnt1,
  output logic          oob,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  // One extra bit so the bound still compares correctly when NPIX == 2**AW.
  localparam logic [AW:0]   NPIX_W    = (AW+1)'(NPIX);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  // Set once the write of LAST_ADDR has been issued; the next cycle ends the sweep.
  logic          clr_last_q, clr_last_d;
  logic          last_q, last_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          px_wr_q, px_wr_d;
  logic          oob_q, oob_d;
  logic          clr_busy_q, clr_busy_d;
  logic          clr_done_q, clr_done_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  // A client granted last cycle still shows its stale req; mask it out.
  logic          elig0, elig1, both, pick;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          sel_oob;

  assign elig0    = req0 & ~gnt0_q;
  assign elig1    = req1 & ~gnt1_q;
  assign both     = elig0 & elig1;
  // On a tie the client that did not win the previous tie goes first.
  assign pick     = both ? ~last_q : elig1;
  assign sel_addr = pick ? addr1 : addr0;
  assign sel_data = pick ? data1 : data0;
  assign sel_oob  = ({1'b0, sel_addr} >= NPIX_W);

  // Next-state and registered-output computation for arbitration and clear sweep.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_last_d = clr_last_q;
    last_d     = last_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    px_wr_d    = 1'b0;
    oob_d      = 1'b0;
    clr_busy_d = clr_busy_q;
    clr_done_d = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    case (state_q)
      S_IDLE: begin
        clr_busy_d = 1'b0;
        if (clr_start) begin
          // Clear takes precedence; pending requests simply wait it out.
          state_d    = S_CLEAR;
          cnt_d      = '0;
          clr_last_d = 1'b0;
          clr_busy_d = 1'b1;
        end else if (elig0 || elig1) begin
          // The tie pointer only moves when both clients actually contended.
          if (both) begin
            last_d = pick;
          end
          gnt0_d = ~pick;
          gnt1_d = pick;
          if (sel_oob) begin
            // Out-of-range write is dropped but the client is still released.
            oob_d = 1'b1;
          end else begin
            px_wr_d = 1'b1;
            addr_d  = sel_addr;
            data_d  = sel_data;
          end
        end
      end

      S_CLEAR: begin
        if (clr_last_q) begin
          state_d    = S_IDLE;
          clr_busy_d = 1'b0;
          clr_done_d = 1'b1;
          clr_last_d = 1'b0;
          cnt_d      = '0;
        end else begin
          clr_busy_d = 1'b1;
          px_wr_d    = 1'b1;
          addr_d     = cnt_q;
          data_d     = CLR_COLOR;
          // Counter saturates at the last valid pixel instead of wrapping.
          if (cnt_q == LAST_ADDR) begin
            clr_last_d = 1'b1;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge gameclk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      clr_last_q <= 1'b0;
      last_q     <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      px_wr_q    <= 1'b0;
      oob_q      <= 1'b0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_last_q <= clr_last_d;
      last_q     <= last_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      px_wr_q    <= px_wr_d;
      oob_q      <= oob_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign px_wr       = px_wr_q;
  assign oob         = oob_q;
  assign clr_busy    = clr_busy_q;
  assign clr_done    = clr_done_q;
  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_write_arbiter
//  Description : Directed and randomized bench for fb_write_arbiter with a
//                transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fb_write_arbiter;

  localparam int         AW        = 8;
  localparam int         DW        = 3;
  localparam int         NPIX      = 192;
  localparam logic [2:0] CLR_COLOR = 3'b111;

  logic          gameclk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_start = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic          clr_busy, clr_done, gnt0, gnt1, oob, px_wr;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;

  fb_write_arbiter #(.AW(AW), .DW(DW), .NPIX(NPIX), .CLR_COLOR(CLR_COLOR)) dut (
    .gameclk     (gameclk),
    .rst         (rst),
    .clr_start   (clr_start),
    .clr_busy    (clr_busy),
    .clr_done    (clr_done),
    .req0        (req0),
    .addr0       (addr0),
    .data0       (data0),
    .gnt0        (gnt0),
    .req1        (req1),
    .addr1       (addr1),
    .data1       (data1),
    .gnt1        (gnt1),
    .oob         (oob),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .px_wr       (px_wr)
  );

  always #5 gameclk = ~gameclk;

  typedef struct packed {
    logic          gnt0;
    logic          gnt1;
    logic          px_wr;
    logic          oob;
    logic          busy;
    logic          done;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } obs_t;

  // Scripted output sequence of a running clear sweep, one entry per cycle.
  obs_t script[$];
  obs_t m_out = '0;
  bit   m_last = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference: what the outputs must be after the coming edge.
  function automatic void model_edge();
    obs_t n;
    obs_t w;
    bit   e0, e1;
    int   win;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    n = '0;
    if (rst) begin
      m_last = 1'b1;
      script.delete();
    end else if (script.size() > 0) begin
      n = script.pop_front();
    end else begin
      n.addr = m_out.addr;
      n.data = m_out.data;
      if (clr_start) begin
        n.busy = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
          w = '0;
          w.busy = 1'b1;
          w.px_wr = 1'b1;
          w.addr = AW'(i);
          w.data = CLR_COLOR;
          script.push_back(w);
        end
        w = '0;
        w.done = 1'b1;
        w.addr = AW'(NPIX - 1);
        w.data = CLR_COLOR;
        script.push_back(w);
      end else begin
        e0 = req0 && !m_out.gnt0;
        e1 = req1 && !m_out.gnt1;
        win = -1;
        if (e0 && e1) begin
          win = m_last ? 0 : 1;
          m_last = (win == 1);
        end else if (e0) begin
          win = 0;
        end else if (e1) begin
          win = 1;
        end
        if (win >= 0) begin
          a = (win == 1) ? addr1 : addr0;
          d = (win == 1) ? data1 : data0;
          if (win == 1) n.gnt1 = 1'b1;
          else          n.gnt0 = 1'b1;
          if (int'(a) < NPIX) begin
            n.px_wr = 1'b1;
            n.addr  = a;
            n.data  = d;
          end else begin
            n.oob = 1'b1;
          end
        end
      end
    end
    m_out = n;
  endfunction

  // Advance one clock and compare every output against the model.
  task automatic tick();
    model_edge();
    @(posedge gameclk);
    #1;
    cyc++;
    check("gnt0",     32'(gnt0),        32'(m_out.gnt0));
    check("gnt1",     32'(gnt1),        32'(m_out.gnt1));
    check("px_wr",    32'(px_wr),       32'(m_out.px_wr));
    check("oob",      32'(oob),         32'(m_out.oob));
    check("clr_busy", 32'(clr_busy),    32'(m_out.busy));
    check("clr_done", 32'(clr_done),    32'(m_out.done));
    check("addr",     32'(mem_px_addr), 32'(m_out.addr));
    check("data",     32'(mem_px_data), 32'(m_out.data));
  endtask

  initial begin
    int writes, dones, last_addr;
    int seq[6];

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_px_wr", 32'(px_wr), 32'd0);
    check("rst_addr",  32'(mem_px_addr), 32'd0);

    // Single client write and stale-request masking
    rst = 1'b0;
    req0 = 1'b1; addr0 = 8'd5; data0 = 3'b010;
    tick();
    check("t1_gnt0", 32'(gnt0), 32'd1);
    check("t1_addr", 32'(mem_px_addr), 32'd5);
    check("t1_data", 32'(mem_px_data), 32'b010);
    tick();
    check("t1_no_regrant", 32'(gnt0), 32'd0);
    req0 = 1'b0;
    tick();

    // Both clients held: alternate 10,20,... starting with client 0
    req0 = 1'b1; addr0 = 8'd10; data0 = 3'b001;
    req1 = 1'b1; addr1 = 8'd20; data1 = 3'b100;
    for (int i = 0; i < 6; i++) begin
      tick();
      seq[i] = px_wr ? int'(mem_px_addr) : -1;
    end
    for (int i = 0; i < 6; i++) begin
      check("t2_alt", 32'(seq[i]), (i % 2 == 0) ? 32'd10 : 32'd20);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Clear beats a simultaneous request; request survives the sweep
    clr_start = 1'b1;
    req1 = 1'b1; addr1 = 8'd33; data1 = 3'b101;
    tick();
    check("t3_no_gnt1", 32'(gnt1), 32'd0);
    check("t3_busy",    32'(clr_busy), 32'd1);
    clr_start = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      tick();
      check("t3_clr_addr", 32'(px_wr ? int'(mem_px_addr) : -1), 32'(i));
    end
    tick();
    check("t3_done", 32'(clr_done), 32'd1);
    tick();
    check("t3_gnt1_after", 32'(gnt1), 32'd1);
    check("t3_addr_after", 32'(mem_px_addr), 32'd33);
    req1 = 1'b0;
    tick();

    // Out-of-range address: grant + oob, no write, address held
    req0 = 1'b1; addr0 = 8'd200; data0 = 3'b011;
    tick();
    check("t4_oob",   32'(oob), 32'd1);
    check("t4_px_wr", 32'(px_wr), 32'd0);
    check("t4_addr",  32'(mem_px_addr), 32'd33);
    req0 = 1'b0;
    tick();

    // Reset aborts a sweep at address 50
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i <= 50; i++) tick();
    check("t5_at50", 32'(mem_px_addr), 32'd50);
    rst = 1'b1;
    tick();
    check("t5_busy0", 32'(clr_busy), 32'd0);
    check("t5_done0", 32'(clr_done), 32'd0);
    rst = 1'b0;
    tick();

    // Restart from 0, ignore a mid-sweep clr_start, exactly NPIX writes
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    check("t5_restart0", 32'(px_wr ? int'(mem_px_addr) : -1), 32'd0);
    writes = 1; dones = 0; last_addr = 0;
    for (int i = 0; i < 260; i++) begin
      clr_start = (i == 80);
      tick();
      if (px_wr) begin writes++; last_addr = int'(mem_px_addr); end
      if (clr_done) dones++;
    end
    clr_start = 1'b0;
    check("t6_writes", 32'(writes), 32'(NPIX));
    check("t6_dones",  32'(dones), 32'd1);
    check("t6_last",   32'(last_addr), 32'(NPIX - 1));

    // Randomized traffic with occasional clears and resets
    for (int i = 0; i < 1500; i++) begin
      if (m_out.gnt0 || !req0) begin
        req0 = 1'($urandom_range(0, 1));
        addr0 = 8'($urandom_range(0, 255));
        data0 = 3'($urandom);
      end
      if (m_out.gnt1 || !req1) begin
        req1 = 1'($urandom_range(0, 1));
        addr1 = 8'($urandom_range(0, 255));
        data1 = 3'($urandom);
      end
      clr_start = ($urandom_range(0, 149) == 0);
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
